// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera-to-SRAM capture bridge.
package cam_pkg;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        VBLANK  = 2'd1,
        FRAME   = 2'd2
    } cam_state_t;

    localparam int ERR_LINE  = 0;
    localparam int ERR_FRAME = 1;

    // Word address of the first word of a given line.
    function automatic int unsigned line_base(input int unsigned line,
                                              input int unsigned words_per_line);
        return line * words_per_line;
    endfunction

endpackage

// File: rtl/cam_xclk_gen.sv
// Sensor master clock divider; strobe marks the clk edge on which xclk rises.
module cam_xclk_gen #(
    parameter int XCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic xclk,
    output logic strobe
);
    localparam int HALF = XCLK_DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt;
    logic          last;

    assign last   = (cnt == CW'(HALF - 1));
    assign strobe = last & ~xclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            xclk <= 1'b0;
        end else if (last) begin
            cnt  <= '0;
            xclk <= ~xclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cam_sram_writer.sv
// Camera capture to 16-bit SRAM bridge with geometry limits and sticky errors.
// Define CAM_DOUBLE_BUFFER_EN to add buf_sel and ping-pong address halves.
module cam_sram_writer
    import cam_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int H_BYTES  = 1280,
    parameter int V_LINES  = 480,
    parameter int XCLK_DIV = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         VSYNC,
    input  logic                         HREF,
    input  logic [7:0]                   din,
    output logic                         xclk,
    output logic                         WEb,
    output logic                         BLEb,
    output logic                         BHEb,
    output logic [ADDR_W-1:0]            SRAM_address,
    output logic [15:0]                  SRAM_data,
    output logic                         frame_done,
    output logic [$clog2(V_LINES+1)-1:0] line_cnt,
`ifdef CAM_DOUBLE_BUFFER_EN
    output logic                         buf_sel,
`endif
    output logic [1:0]                   err
);
    localparam int LW  = $clog2(V_LINES + 1);
    localparam int BW  = $clog2(H_BYTES + 1);
    localparam int WPL = H_BYTES / 2;

    cam_state_t    state, next_state;
    logic          strobe;
    logic          vs_prev, href_prev;
    logic [BW-1:0] byte_cnt;
    logic          vs_rise, vs_fall, frame_start, frame_end;
    logic          active, line_full, wr, href_rise, href_fall;
    logic [ADDR_W-1:0] wr_addr;

    cam_xclk_gen #(.XCLK_DIV(XCLK_DIV)) u_xclk (
        .clk    (clk),
        .rst    (rst),
        .xclk   (xclk),
        .strobe (strobe)
    );

    assign vs_rise = VSYNC & ~vs_prev;
    assign vs_fall = ~VSYNC & vs_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_VS;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            WAIT_VS: if (VSYNC) next_state = VBLANK;
            VBLANK: if (vs_fall && enable) begin
                next_state  = FRAME;
                frame_start = 1'b1;
            end
            FRAME: if (vs_rise) begin
                next_state = VBLANK;
                frame_end  = 1'b1;
            end
            default: next_state = WAIT_VS;
        endcase
    end

    // A VSYNC rise wins over any line activity on the same strobe (abort).
    assign active    = strobe && (state == FRAME) && !frame_end;
    assign line_full = (line_cnt == LW'(V_LINES));
    assign href_rise = HREF & ~href_prev;
    assign href_fall = ~HREF & href_prev;
    assign wr        = active && HREF && !line_full && (byte_cnt < BW'(H_BYTES));

`ifdef CAM_DOUBLE_BUFFER_EN
    assign wr_addr = ADDR_W'(line_base(32'(line_cnt), WPL) + 32'(byte_cnt >> 1))
                   | {buf_sel, {(ADDR_W-1){1'b0}}};
`else
    assign wr_addr = ADDR_W'(line_base(32'(line_cnt), WPL) + 32'(byte_cnt >> 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev      <= 1'b0;
            href_prev    <= 1'b0;
            byte_cnt     <= '0;
            line_cnt     <= '0;
            WEb          <= 1'b1;
            BLEb         <= 1'b1;
            BHEb         <= 1'b1;
            SRAM_address <= '0;
            SRAM_data    <= '0;
            frame_done   <= 1'b0;
            err          <= '0;
`ifdef CAM_DOUBLE_BUFFER_EN
            buf_sel      <= 1'b0;
`endif
        end else begin
            vs_prev    <= VSYNC;
            frame_done <= frame_end;
            WEb        <= 1'b1;
            BLEb       <= 1'b1;
            BHEb       <= 1'b1;
`ifdef CAM_DOUBLE_BUFFER_EN
            if (frame_end) buf_sel <= ~buf_sel;
`endif
            if (strobe) href_prev <= HREF;
            if (frame_start) begin
                line_cnt     <= '0;
                byte_cnt     <= '0;
                SRAM_address <= '0;
                href_prev    <= 1'b0;
            end else if (active) begin
                if (wr) begin
                    WEb          <= 1'b0;
                    BLEb         <= byte_cnt[0];
                    BHEb         <= ~byte_cnt[0];
                    SRAM_address <= wr_addr;
                    SRAM_data    <= {din, din};
                    byte_cnt     <= byte_cnt + 1'b1;
                end else if (HREF && !line_full) begin
                    err[ERR_LINE] <= 1'b1;
                end
                if (href_rise && line_full) err[ERR_FRAME] <= 1'b1;
                if (href_fall) begin
                    byte_cnt <= '0;
                    if (!line_full) line_cnt <= line_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_sram_writer.sv
// Randomized self-checking bench for cam_sram_writer against a frame-level model.
module tb_cam_sram_writer;
    localparam int ADDR_W   = 8;
    localparam int H_BYTES  = 8;
    localparam int V_LINES  = 4;
    localparam int XCLK_DIV = 2;
    localparam int LW       = $clog2(V_LINES + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              VSYNC = 1'b0;
    logic              HREF = 1'b0;
    logic [7:0]        din = 8'h00;
    logic              xclk, WEb, BLEb, BHEb, frame_done;
    logic [ADDR_W-1:0] SRAM_address;
    logic [15:0]       SRAM_data;
    logic [LW-1:0]     line_cnt;
    logic [1:0]        err;
`ifdef CAM_DOUBLE_BUFFER_EN
    logic              buf_sel;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    int          line_len[$];
    int          m_lines = 0;
    logic [1:0]  m_err = 2'b00;
    int          m_buf = 0;
    int          fd_cnt = 0;
    bit          sb_en = 1'b0;
    logic [7:0]  seed = 8'h00;

    cam_sram_writer #(
        .ADDR_W(ADDR_W), .H_BYTES(H_BYTES), .V_LINES(V_LINES), .XCLK_DIV(XCLK_DIV)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .VSYNC(VSYNC), .HREF(HREF), .din(din),
        .xclk(xclk), .WEb(WEb), .BLEb(BLEb), .BHEb(BHEb),
        .SRAM_address(SRAM_address), .SRAM_data(SRAM_data),
        .frame_done(frame_done), .line_cnt(line_cnt),
`ifdef CAM_DOUBLE_BUFFER_EN
        .buf_sel(buf_sel),
`endif
        .err(err)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_val(input int l, input int k);
        return 8'(int'(seed) + l * 16 + k);
    endfunction

    // Expected writes for a whole frame from the geometry rules.
    task automatic model_frame(input bit en, input int ab_line, input int ab_byte);
        int n;
        int off;
        logic [ADDR_W-1:0] a;
        logic [7:0] b;
        if (!en) return;
`ifdef CAM_DOUBLE_BUFFER_EN
        off = m_buf * (1 << (ADDR_W - 1));
`else
        off = 0;
`endif
        m_lines = 0;
        for (int l = 0; l < line_len.size(); l++) begin
            n = (l == ab_line) ? ab_byte : line_len[l];
            if (m_lines == V_LINES) begin
                if (n > 0) m_err[1] = 1'b1;
            end else begin
                for (int k = 0; k < n; k++) begin
                    if (k < H_BYTES) begin
                        a = ADDR_W'(off + m_lines * (H_BYTES / 2) + k / 2);
                        b = byte_val(l, k);
                        exp_q.push_back({6'b0, (k % 2 == 1) ? 2'b01 : 2'b10, a, b, b});
                    end else begin
                        m_err[0] = 1'b1;
                    end
                end
            end
            if (l == ab_line) break;
            if (m_lines < V_LINES) m_lines++;
        end
        m_buf ^= 1;
    endtask

    // driver: sensor changes outputs on pclk rise = xclk fall
    task automatic pcycle(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge xclk);
        #1;
        VSYNC = vs;
        HREF  = hr;
        din   = d;
    endtask

    task automatic run_frame(input bit en, input int ab_line, input int ab_byte, input string tag);
        bit aborted = 1'b0;
        model_frame(en, ab_line, ab_byte);
        fd_cnt = 0;
        repeat (3) pcycle(1'b1, 1'b0, 8'h00);
        enable = en;
        pcycle(1'b0, 1'b0, 8'h00);
        pcycle(1'b0, 1'b0, 8'h00);
        for (int l = 0; l < line_len.size(); l++) begin
            for (int k = 0; k < line_len[l]; k++) begin
                if (l == ab_line && k == ab_byte) begin
                    aborted = 1'b1;
                    break;
                end
                pcycle(1'b0, 1'b1, byte_val(l, k));
            end
            if (aborted) break;
            pcycle(1'b0, 1'b0, 8'h00);
            pcycle(1'b0, 1'b0, 8'h00);
        end
        if (aborted) pcycle(1'b1, 1'b1, 8'h00);
        repeat (4) pcycle(1'b1, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_frame_done"}, 32'(fd_cnt), en ? 32'd1 : 32'd0);
        chk({tag, "_line_cnt"}, 32'(line_cnt), 32'(m_lines));
        chk({tag, "_err"}, 32'(err), 32'(m_err));
        exp_q.delete();
    endtask

    // scoreboard: every write strobe must match the head of exp_q
    always @(negedge clk) begin
        logic [31:0] act;
        logic [31:0] exp;
        if (!rst && sb_en) begin
            if (frame_done) fd_cnt++;
            if (!WEb) begin
                act = {6'b0, BHEb, BLEb, SRAM_address, SRAM_data};
                exp = (exp_q.size() == 0) ? 32'hFFFF_FFFF : exp_q.pop_front();
                chk("write", act, exp);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_xclk"}, 32'(xclk), 32'd0);
        chk({tag, "_strobes"}, 32'({WEb, BLEb, BHEb}), 32'd7);
        chk({tag, "_addr"}, 32'(SRAM_address), 32'd0);
        chk({tag, "_data"}, 32'(SRAM_data), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_line_cnt"}, 32'(line_cnt), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
`ifdef CAM_DOUBLE_BUFFER_EN
        chk({tag, "_buf_sel"}, 32'(buf_sel), 32'd0);
`endif
    endtask

    initial begin
        int nl;
        int ab_line;
        int ab_byte;
        bit found;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst   = 1'b0;
        sb_en = 1'b1;

        seed = 8'h10;
        line_len = '{8, 8, 8, 8};
        run_frame(1'b1, -1, 0, "basic");

        seed = 8'($urandom);
        line_len = '{10, 8, 8, 8};
        run_frame(1'b1, -1, 0, "long_line");

        seed = 8'($urandom);
        line_len = '{8, 8, 8, 8, 8};
        run_frame(1'b1, -1, 0, "extra_line");

        seed = 8'($urandom);
        line_len = '{8, 8};
        run_frame(1'b0, -1, 0, "enable_low");
        line_len = '{8, 8, 8, 8};
        run_frame(1'b1, -1, 0, "enable_high");

        seed = 8'($urandom);
        line_len = '{8, 8, 8, 8};
        run_frame(1'b1, 2, 3, "abort");

        repeat (10) begin
            seed = 8'($urandom);
            line_len.delete();
            nl = $urandom_range(1, 5);
            for (int i = 0; i < nl; i++) line_len.push_back($urandom_range(1, 10));
            ab_line = -1;
            ab_byte = 0;
            if ($urandom_range(0, 3) == 0) begin
                ab_line = $urandom_range(0, nl - 1);
                if (line_len[ab_line] >= 2) ab_byte = $urandom_range(1, line_len[ab_line] - 1);
                else ab_line = -1;
            end
            run_frame($urandom_range(0, 4) != 0, ab_line, ab_byte, "random");
        end

        // reset asserted while a write strobe is low
        sb_en = 1'b0;
        enable = 1'b1;
        pcycle(1'b1, 1'b0, 8'h00);
        pcycle(1'b0, 1'b0, 8'h00);
        pcycle(1'b0, 1'b0, 8'h00);
        pcycle(1'b0, 1'b1, 8'hAB);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!WEb) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_mid_wr_seen", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        HREF = 1'b0;
        VSYNC = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_lines = 0;
        m_err = 2'b00;
        m_buf = 0;
        exp_q.delete();
        sb_en = 1'b1;
        seed = 8'($urandom);
        line_len = '{8, 8, 8, 8};
        run_frame(1'b1, -1, 0, "recover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
